sift_histo_stream_reader: RTL and testbench

//  Read side of the SIFT orientation-histogram stage. Captures one parallel descriptor

---
 rtl/sift_histo_stream_reader_if.sv | 37 +++
 rtl/sift_histo_stream_reader.sv | 138 +++++++++++++
 tb/tb_sift_histo_stream_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sift_histo_stream_reader_if.sv
// Bundle of the descriptor-capture handshake, the beat stream and the per-region peak report
// for sift_histo_stream_reader. slave = the reader block, master = its surroundings.
interface sift_histo_stream_reader_if #(
  parameter int histoDataW = 8,
  parameter int histoL     = 8,
  parameter int regionN    = 9
);
  localparam int RGN_W = $clog2(regionN);
  localparam int BIN_W = $clog2(histoL);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [regionN*histoL*histoDataW-1:0] histo_in;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [histoDataW-1:0]                bin_data;
  logic [RGN_W-1:0]                     bin_region;
  logic [BIN_W-1:0]                     bin_idx;
  logic                                 region_last;
  logic                                 desc_last;
  logic                                 peak_valid;
  logic [RGN_W-1:0]                     peak_region;
  logic [BIN_W-1:0]                     peak_bin;
  logic [histoDataW-1:0]                peak_mag;

  modport slave (
    input  in_valid, histo_in, out_ready,
    output in_ready, out_valid, bin_data, bin_region, bin_idx, region_last, desc_last,
           peak_valid, peak_region, peak_bin, peak_mag
  );

  modport master (
    output in_valid, histo_in, out_ready,
    input  in_ready, out_valid, bin_data, bin_region, bin_idx, region_last, desc_last,
           peak_valid, peak_region, peak_bin, peak_mag
  );
endinterface

// File: rtl/sift_histo_stream_reader.sv
// Captures one regionN x histoL descriptor, streams it one bin per beat and reports each region's argmax.
// Optional macro DESC_CLAMP_EN: saturate streamed bins at CLAMP_MAX (peak tracker stays on raw values).
module sift_histo_stream_reader #(
  parameter int histoDataW = 8,
  parameter int histoL     = 8,
  parameter int regionN    = 9,
  parameter int CLAMP_MAX  = 51
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sift_histo_stream_reader_if.slave bus
);
  localparam int NBEATS = regionN * histoL;
  localparam int RGN_W  = $clog2(regionN);
  localparam int BIN_W  = $clog2(histoL);
  localparam int PTR_W  = $clog2(NBEATS);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                r_state, w_state_nxt;
  logic                  w_in_ready, w_out_valid, w_capture, w_xfer;
  logic                  w_region_last, w_desc_last;
  logic [histoDataW-1:0] r_buf [NBEATS];
  logic [RGN_W-1:0]      r_region;
  logic [BIN_W-1:0]      r_bin;
  logic [PTR_W-1:0]      r_ptr;
  logic [histoDataW-1:0] w_raw, w_bin_out;
  logic [histoDataW-1:0] r_max_mag, w_max_mag_nxt;
  logic [BIN_W-1:0]      r_max_bin, w_max_bin_nxt;
  logic                  r_peak_valid;
  logic [RGN_W-1:0]      r_peak_region;
  logic [BIN_W-1:0]      r_peak_bin;
  logic [histoDataW-1:0] r_peak_mag;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_out_valid = 1'b1;
        if (bus.out_ready && w_desc_last) w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_capture     = w_in_ready & bus.in_valid;
  assign w_xfer        = w_out_valid & bus.out_ready;
  assign w_region_last = (r_bin == BIN_W'(histoL - 1));
  assign w_desc_last   = (r_ptr == PTR_W'(NBEATS - 1));

  // Counters return to zero after the final beat, so IDLE always presents region 0, bin 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_region <= '0;
      r_bin    <= '0;
      r_ptr    <= '0;
    end else if (w_capture) begin
      r_region <= '0;
      r_bin    <= '0;
      r_ptr    <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_desc_last ? '0 : r_ptr + 1'b1;
      r_bin <= w_region_last ? '0 : r_bin + 1'b1;
      if (w_region_last) r_region <= w_desc_last ? '0 : r_region + 1'b1;
    end
  end

  // NOTE: the snapshot buffer has no reset; its contents only reach outputs while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NBEATS; i++) r_buf[i] <= bus.histo_in[i*histoDataW +: histoDataW];
    end
  end

  assign w_raw = r_buf[r_ptr];

`ifdef DESC_CLAMP_EN
  assign w_bin_out = (w_raw > histoDataW'(CLAMP_MAX)) ? histoDataW'(CLAMP_MAX) : w_raw;
`else
  assign w_bin_out = w_raw;
`endif

  // Bin 0 reloads the running max; later bins replace it only when strictly larger.
  always_comb begin
    w_max_mag_nxt = r_max_mag;
    w_max_bin_nxt = r_max_bin;
    if (r_bin == '0 || w_raw > r_max_mag) begin
      w_max_mag_nxt = w_raw;
      w_max_bin_nxt = r_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_mag     <= '0;
      r_max_bin     <= '0;
      r_peak_valid  <= 1'b0;
      r_peak_region <= '0;
      r_peak_bin    <= '0;
      r_peak_mag    <= '0;
    end else begin
      r_peak_valid <= w_xfer & w_region_last;
      if (w_xfer) begin
        r_max_mag <= w_max_mag_nxt;
        r_max_bin <= w_max_bin_nxt;
      end
      if (w_xfer && w_region_last) begin
        r_peak_region <= r_region;
        r_peak_bin    <= w_max_bin_nxt;
        r_peak_mag    <= w_max_mag_nxt;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.bin_data    = w_out_valid ? w_bin_out : '0;
  assign bus.bin_region  = r_region;
  assign bus.bin_idx     = r_bin;
  assign bus.region_last = w_out_valid & w_region_last;
  assign bus.desc_last   = w_out_valid & w_desc_last;
  assign bus.peak_valid  = r_peak_valid;
  assign bus.peak_region = r_peak_region;
  assign bus.peak_bin    = r_peak_bin;
  assign bus.peak_mag    = r_peak_mag;
endmodule

// File: tb/tb_sift_histo_stream_reader.sv
// Self-checking bench for sift_histo_stream_reader: random and directed descriptors, random
// backpressure, mid-stream reset, checked against a beat-list / argmax reference model.
module tb_sift_histo_stream_reader;
  localparam int DW = 8;
  localparam int L  = 8;
  localparam int R  = 9;
  localparam int NB = R * L;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   desc [R][L];

  sift_histo_stream_reader_if #(.histoDataW(DW), .histoL(L), .regionN(R)) bus ();

  sift_histo_stream_reader #(.histoDataW(DW), .histoL(L), .regionN(R), .CLAMP_MAX(51)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_data(input int v);
`ifdef DESC_CLAMP_EN
    return (v > 51) ? 51 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    bus.in_ready,    1);
    check({tag, "_out_valid"},   bus.out_valid,   0);
    check({tag, "_peak_valid"},  bus.peak_valid,  0);
    check({tag, "_bin_data"},    bus.bin_data,    0);
    check({tag, "_bin_region"},  bus.bin_region,  0);
    check({tag, "_bin_idx"},     bus.bin_idx,     0);
    check({tag, "_region_last"}, bus.region_last, 0);
    check({tag, "_desc_last"},   bus.desc_last,   0);
    check({tag, "_peak_region"}, bus.peak_region, 0);
    check({tag, "_peak_bin"},    bus.peak_bin,    0);
    check({tag, "_peak_mag"},    bus.peak_mag,    0);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < R; r++)
      for (int b = 0; b < L; b++) desc[r][b] = r * L + b;
  endtask

  task automatic fill_random(input int maxv);
    for (int r = 0; r < R; r++)
      for (int b = 0; b < L; b++) desc[r][b] = $urandom_range(0, maxv);
  endtask

  // Ties in region 0, an all-zero region 4 and an over-clamp value in region 1.
  task automatic fill_ties();
    int tie [L];
    tie = '{5, 9, 9, 3, 9, 0, 0, 0};
    fill_ramp();
    for (int b = 0; b < L; b++) begin
      desc[0][b] = tie[b];
      desc[4][b] = 0;
    end
    desc[1][3] = 200;
  endtask

  // bp_mode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,1 during region 2.
  // abort_at > 0 pulls rst_n after that many transfers.
  task automatic run_desc(input int bp_mode, input int abort_at);
    logic [NB*DW-1:0] flat;
    int   pk_bin [R];
    int   pk_mag [R];
    int   beat, cyc, pr, k;
    logic rdy, pulse_due;
    bit [3:0] pat;
    pat = 4'b1001;
    for (int r = 0; r < R; r++) begin
      pk_bin[r] = 0;
      for (int b = 0; b < L; b++) begin
        flat[(r*L+b)*DW +: DW] = DW'(desc[r][b]);
        if (desc[r][b] > desc[r][pk_bin[r]]) pk_bin[r] = b;
      end
      pk_mag[r] = desc[r][pk_bin[r]];
    end

    bus.in_valid  = 1'b1;
    bus.histo_in  = flat;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_out_valid", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    bus.histo_in = ~flat;

    beat = 0; cyc = 0; pr = 0; k = 0; pulse_due = 1'b0;
    while (beat < NB && cyc < 2000) begin
      case (bp_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: begin
          if (beat / L == 2) begin
            rdy = pat[k % 4];
            k++;
          end else rdy = 1'b1;
        end
      endcase
      bus.out_ready = rdy;
      bus.in_valid  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("out_valid", bus.out_valid, 1);
      check("busy_in_ready", bus.in_ready, 0);
      check("bin_data", bus.bin_data, exp_data(desc[beat/L][beat%L]));
      check("bin_region", bus.bin_region, beat / L);
      check("bin_idx", bus.bin_idx, beat % L);
      check("region_last", bus.region_last, (beat % L) == L - 1);
      check("desc_last", bus.desc_last, beat == NB - 1);
      check("peak_valid", bus.peak_valid, pulse_due);
      if (pulse_due) begin
        check("peak_region", bus.peak_region, pr);
        check("peak_bin", bus.peak_bin, pk_bin[pr]);
        check("peak_mag", bus.peak_mag, pk_mag[pr]);
      end
      pulse_due = rdy && ((beat % L) == L - 1);
      pr        = beat / L;
      if (rdy) beat++;
      cyc++;
      tick();
      if (abort_at > 0 && beat == abort_at) begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        return;
      end
    end
    if (beat < NB) check("stream_timeout", beat, NB);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("end_out_valid", bus.out_valid, 0);
    check("end_in_ready", bus.in_ready, 1);
    check("end_peak_valid", bus.peak_valid, pulse_due);
    check("end_peak_region", bus.peak_region, R - 1);
    check("end_peak_bin", bus.peak_bin, pk_bin[R-1]);
    check("end_peak_mag", bus.peak_mag, pk_mag[R-1]);
    tick();
    @(negedge clk);
    check("pulse_width", bus.peak_valid, 0);
    check("peak_hold_mag", bus.peak_mag, pk_mag[R-1]);
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.histo_in  = '1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();

    fill_ramp();
    run_desc(0, 0);
    run_desc(2, 0);
    fill_ties();
    run_desc(0, 0);
    fill_random(15);
    run_desc(1, 0);
    fill_random(255);
    run_desc(1, 30);
    fill_ramp();
    run_desc(0, 0);
    for (int n = 0; n < 3; n++) begin
      fill_random((n == 1) ? 7 : 255);
      run_desc(1, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
